fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the PPU pipeline. Holds PC/nPC (delayed-branch model), reads a
//   byte-addressed big-endian instruction ROM and loads the IF/ID pipeline register that feeds
//   decode. Consumes stall from hazard unit and branch/annul decisions resolved in ID.
// PARAMETERS
//   ROM_BYTES  512  instruction ROM size in bytes (power of two); array Mem[0:ROM_BYTES-1], 8-bit
//   RESET_PC   0    PC value after reset; nPC resets to RESET_PC+4
//   NOP_WORD   0    word inserted into IF/ID on annul/flush
// PORTS
//   clk          in   1   pipeline clock, all state updates on rising edge
//   reset        in   1   synchronous, active-high reset
//   stall        in   1   hold PC, nPC and IF/ID (load-use hazard)
//   branch_taken in   1   branch/jump in ID resolved taken this cycle
//   branch_tgt   in   32  target address from ID
//   annul        in   1   squash instruction currently fetched (delay slot) into IF/ID
//   PC_IF        out  32  current fetch address (PC)
//   npc_if       out  32  current nPC
//   instr_id     out  32  IF/ID instruction
//   pc_id        out  32  IF/ID PC of that instruction
//   valid_id     out  1   IF/ID holds a real (non-squashed) instruction
// BEHAVIOUR
//   Reset (reset=1 at posedge): PC=RESET_PC, nPC=RESET_PC+4, instr_id=NOP_WORD, pc_id=0,
//     valid_id=0. reset overrides every other input, incl. mid-stall/mid-branch.
//   ROM read combinational: word = {Mem[a],Mem[a+1],Mem[a+2],Mem[a+3]}, a = PC[1:0] forced 00,
//     index taken mod ROM_BYTES (upper PC bits ignored -> wrap-around, no fault).
//   Priority per posedge (reset=0): stall > branch/annul > sequential.
//   stall=1: PC, nPC, IF/ID all hold; branch_taken/annul ignored that cycle (ID re-asserts).
//   stall=0, branch_taken=0: PC<=nPC; nPC<=nPC+4 (32-bit, wraps at 2^32).
//   stall=0, branch_taken=1: PC<=nPC (delay slot executes); nPC<={branch_tgt[31:2],2'b00}.
//   IF/ID load (stall=0): annul=0 -> instr_id<=ROM word @PC, pc_id<=PC, valid_id<=1;
//     annul=1 -> instr_id<=NOP_WORD, pc_id<=PC, valid_id<=0. annul independent of branch_taken
//     (both may be 1: delay slot squashed and redirect taken).
//   Latency: instruction at PC appears on instr_id 1 cycle later; branch resolved in ID takes
//     effect on PC 2 cycles later (delay slot between).
//   First cycle after reset release: fetch at RESET_PC, valid_id rises next edge.
//   No internal FSM beyond PC/nPC/IF-ID regs; all outputs registered except none (PC_IF=PC reg).
// TESTING
//   1 reset 2 cycles, ROM bytes 0..11 = words A,B,C -> PC_IF 0,4,8; instr_id A,B with pc_id 0,4
//     one cycle behind; valid_id 0 until first post-reset edge.
//   2 at PC=8 assert branch_taken, tgt=40 one cycle -> PC_IF 12 (delay slot) then 40, 44;
//     instr_id @12 valid_id=1.
//   3 branch_taken+annul, tgt=40, PC=12 -> next instr_id=NOP_WORD, valid_id=0, pc_id=12; PC 16->40.
//   4 stall held 3 cycles at PC=20 -> PC_IF, instr_id, pc_id unchanged; branch_taken pulsed during
//     stall ignored; resumes 24 after release.
//   5 tgt=0x0000_0213 (misaligned, > ROM_BYTES) -> nPC=0x210, ROM index 0x10 (wrap), word @16.
//   6 reset asserted mid-branch (nPC=40 pending) -> next edge PC=0, nPC=4, valid_id=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC/nPC delayed-branch sequencing, big-endian byte ROM read,
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int unsigned             ROM_BYTES = 512,
  parameter logic [31:0]             RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]             NOP_WORD  = 32'h0000_0000,
  // Byte i of the ROM lives at ROM_INIT[8*i +: 8]
  parameter logic [ROM_BYTES*8-1:0]  ROM_INIT  = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_tgt,
  input  logic        annul,
  output logic [31:0] PC_IF,
  output logic [31:0] npc_if,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic        valid_id
);

  localparam int unsigned IDX_W = $clog2(ROM_BYTES);

  logic [7:0]       mem [0:ROM_BYTES-1];
  logic [IDX_W-1:0] rom_idx_s;
  logic [31:0]      rom_word_s;

  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_q, valid_d;

  for (genvar gi = 0; gi < ROM_BYTES; gi++) begin : g_mem
    assign mem[gi] = ROM_INIT[gi*8 +: 8];
  end

  // Upper PC bits are dropped so fetches beyond the ROM wrap instead of faulting
  assign rom_idx_s  = {pc_q[IDX_W-1:2], 2'b00};
  assign rom_word_s = {mem[{rom_idx_s[IDX_W-1:2], 2'b00}],
                       mem[{rom_idx_s[IDX_W-1:2], 2'b01}],
                       mem[{rom_idx_s[IDX_W-1:2], 2'b10}],
                       mem[{rom_idx_s[IDX_W-1:2], 2'b11}]};

  // Next-state: stall freezes everything, otherwise advance and load IF/ID
  always_comb begin
    pc_d    = pc_q;
    npc_d   = npc_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    valid_d = valid_q;
    if (stall) begin
      pc_d    = pc_q;
    end else begin
      pc_d    = npc_q;
      pc_id_d = pc_q;
      if (branch_taken) begin
        npc_d = {branch_tgt[31:2], 2'b00};
      end else begin
        npc_d = npc_q + 32'd4;
      end
      if (annul) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end else begin
        instr_d = rom_word_s;
        valid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset overriding every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      instr_q <= NOP_WORD;
      pc_id_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      valid_q <= valid_d;
    end
  end

  assign PC_IF    = pc_q;
  assign npc_if   = npc_q;
  assign instr_id = instr_q;
  assign pc_id    = pc_id_q;
  assign valid_id = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: sequential fetch, delayed branch,
// annul, stall, misaligned/wrapping targets, nPC wrap and reset overriding branch/stall.
module tb_fetch_stage;

  localparam int unsigned ROM_BYTES = 512;
  localparam logic [31:0] NOP_W     = 32'h0100_0000;

  function automatic logic [ROM_BYTES*8-1:0] build_rom();
    logic [ROM_BYTES*8-1:0] r;
    logic [7:0] hdr [0:11];
    hdr = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
            8'hC1, 8'hC2, 8'hC3, 8'hC4};
    r = '0;
    for (int i = 0; i < ROM_BYTES; i++) begin
      if (i < 12) r[i*8 +: 8] = hdr[i];
      else        r[i*8 +: 8] = 8'(i) ^ 8'h3C ^ 8'(i >> 8);
    end
    return r;
  endfunction

  localparam logic [ROM_BYTES*8-1:0] ROM = build_rom();

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    int unsigned idx;
    idx = (addr % ROM_BYTES) & ~32'd3;
    return {ROM[idx*8 +: 8], ROM[(idx+1)*8 +: 8], ROM[(idx+2)*8 +: 8], ROM[(idx+3)*8 +: 8]};
  endfunction

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, annul;
  logic [31:0] branch_tgt;
  logic [31:0] PC_IF, npc_if, instr_id, pc_id;
  logic        valid_id;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.ROM_BYTES(ROM_BYTES), .RESET_PC(32'h0), .NOP_WORD(NOP_W), .ROM_INIT(ROM)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_tgt(branch_tgt), .annul(annul), .PC_IF(PC_IF), .npc_if(npc_if),
    .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        b;
    logic        a;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] iaddr;
    logic        nop;
    logic [31:0] pcid;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic a,
                      input logic [31:0] tgt);
    @(negedge clk);
    reset = r; stall = s; branch_taken = b; annul = a; branch_tgt = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                           input logic [31:0] instr, input logic [31:0] pcid, input logic v);
    chk({tag, " PC_IF"},    PC_IF,    pc);
    chk({tag, " npc_if"},   npc_if,   npc);
    chk({tag, " instr_id"}, instr_id, instr);
    chk({tag, " pc_id"},    pc_id,    pcid);
    chk({tag, " valid_id"}, {31'd0, valid_id}, {31'd0, v});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; annul = 1'b0; branch_tgt = 32'd0;

    // s, b, a, tgt, expected PC, nPC, fetched address of instr_id, squashed, pc_id
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd4,   32'd8,   32'd0,   1'b0, 32'd0});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd8,   32'd12,  32'd4,   1'b0, 32'd4});
    tv.push_back('{1'b0, 1'b1, 1'b0, 32'd40,  32'd12,  32'd40,  32'd8,   1'b0, 32'd8});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd40,  32'd44,  32'd12,  1'b0, 32'd12});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd44,  32'd48,  32'd40,  1'b0, 32'd40});
    tv.push_back('{1'b0, 1'b1, 1'b0, 32'd8,   32'd48,  32'd8,   32'd44,  1'b0, 32'd44});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd8,   32'd12,  32'd48,  1'b0, 32'd48});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd12,  32'd16,  32'd8,   1'b0, 32'd8});
    tv.push_back('{1'b0, 1'b1, 1'b1, 32'd40,  32'd16,  32'd40,  32'd0,   1'b1, 32'd12});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd40,  32'd44,  32'd16,  1'b0, 32'd16});
    tv.push_back('{1'b0, 1'b1, 1'b0, 32'd16,  32'd44,  32'd16,  32'd40,  1'b0, 32'd40});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd16,  32'd20,  32'd44,  1'b0, 32'd44});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd20,  32'd24,  32'd16,  1'b0, 32'd16});
    tv.push_back('{1'b1, 1'b0, 1'b0, 32'd0,   32'd20,  32'd24,  32'd16,  1'b0, 32'd16});
    tv.push_back('{1'b1, 1'b1, 1'b0, 32'd100, 32'd20,  32'd24,  32'd16,  1'b0, 32'd16});
    tv.push_back('{1'b1, 1'b1, 1'b1, 32'd100, 32'd20,  32'd24,  32'd16,  1'b0, 32'd16});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd24,  32'd28,  32'd20,  1'b0, 32'd20});
    tv.push_back('{1'b0, 1'b1, 1'b0, 32'h213, 32'd28,  32'h210, 32'd24,  1'b0, 32'd24});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'h210, 32'h214, 32'd28,  1'b0, 32'd28});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'h214, 32'h218, 32'h210, 1'b0, 32'h210});
    tv.push_back('{1'b0, 1'b0, 1'b1, 32'd0,   32'h218, 32'h21C, 32'd0,   1'b1, 32'h214});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'h21C, 32'h220, 32'h218, 1'b0, 32'h218});
    tv.push_back('{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h220, 32'hFFFF_FFFC, 32'h21C, 1'b0, 32'h21C});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'hFFFF_FFFC, 32'd0, 32'h220, 1'b0, 32'h220});
    tv.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   32'd0,   32'd4,   32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC});
    tv.push_back('{1'b0, 1'b1, 1'b0, 32'd40,  32'd4,   32'd40,  32'd0,   1'b0, 32'd0});

    // Reset held for two edges
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_state("reset1", 32'd0, 32'd4, NOP_W, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_state("reset2", 32'd0, 32'd4, NOP_W, 32'd0, 1'b0);

    for (int i = 0; i < tv.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(1'b0, tv[i].s, tv[i].b, tv[i].a, tv[i].tgt);
      chk_state(tag, tv[i].pc, tv[i].npc,
                tv[i].nop ? NOP_W : rom_word(tv[i].iaddr), tv[i].pcid, ~tv[i].nop);
    end

    // Header words must arrive big-endian exactly as laid out in the ROM
    chk("rom_word_A", rom_word(32'd0), 32'hA1A2_A3A4);

    // Reset while a branch is pending (nPC=40) and another branch is asserted
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd80);
    chk_state("rst_midbranch", 32'd0, 32'd4, NOP_W, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_state("post_rst", 32'd4, 32'd8, 32'hA1A2_A3A4, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_state("post_rst2", 32'd8, 32'd12, 32'hB1B2_B3B4, 32'd4, 1'b1);

    // Reset overrides stall
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk_state("rst_midstall", 32'd0, 32'd4, NOP_W, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_state("post_rst3", 32'd4, 32'd8, 32'hA1A2_A3A4, 32'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
